// File: rtl/spi_shift_in_reg_pkg.sv
// SPI receive-side shared constants and FSM state type.
// Also consumed by the MISO shift-out path for identical framing.
package spi_shift_in_reg_pkg;

  // Synchronizer depth for raw pad inputs.
  localparam int unsigned SPI_SYNC_STAGES = 2;

  // Mode 0: data is sampled on the SCLK rising edge.
  localparam bit SPI_SAMPLE_RISE = 1'b1;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

  // Edge detect on a synchronized clock tap, polarity set by mode.
  function automatic logic spi_edge(
    input logic cur,
    input logic prev
  );
    if (SPI_SAMPLE_RISE)
      return cur & ~prev;
    else
      return ~cur & prev;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Pad synchronizer for SCLK/CS_N/MOSI.
// SCLK gets one extra flop so its sampling edge can be detected.
module spi_in_sync
  import spi_shift_in_reg_pkg::*;
(
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_SCLK,
  input  logic i_CS_N,
  input  logic i_MOSI,
  output logic o_SCLK_EDGE,
  output logic o_CS_S2,
  output logic o_MOSI_S2
);

  localparam int unsigned N = SPI_SYNC_STAGES;

  logic [N:0]   sclk_q;
  logic [N-1:0] cs_q;
  logic [N-1:0] mosi_q;

  // Shift pad levels in; reset to idle bus levels.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[N-1:0], i_SCLK};
      cs_q   <= {cs_q[N-2:0], i_CS_N};
      mosi_q <= {mosi_q[N-2:0], i_MOSI};
    end
  end

  assign o_SCLK_EDGE = spi_edge(sclk_q[N-1], sclk_q[N]);
  assign o_CS_S2     = cs_q[N-1];
  assign o_MOSI_S2   = mosi_q[N-1];

endmodule

// File: rtl/spi_shift_in_reg.sv
// SPI mode-0 slave MOSI deserializer.
// Words land in a holding register with a valid/ready handshake.
module spi_shift_in_reg
  import spi_shift_in_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_SCLK,
  input  logic                  i_CS_N,
  input  logic                  i_MOSI,
  input  logic                  i_READY,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_VALID,
  output logic                  o_BUSY,
  output logic                  o_FRAME_ERR,
  output logic                  o_OVERRUN
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sclk_edge;
  logic cs_s2;
  logic mosi_s2;

  rx_state_e             state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] sr_next;
  logic                  take;

  spi_in_sync u_sync (
    .i_CLK       (i_CLK),
    .i_RST_N     (i_RST_N),
    .i_SCLK      (i_SCLK),
    .i_CS_N      (i_CS_N),
    .i_MOSI      (i_MOSI),
    .o_SCLK_EDGE (sclk_edge),
    .o_CS_S2     (cs_s2),
    .o_MOSI_S2   (mosi_s2)
  );

  // Shift register with the current bit applied.
  always_comb begin
    if (MSB_FIRST)
      sr_next = {sr[DATA_WIDTH-2:0], mosi_s2};
    else
      sr_next = {mosi_s2, sr[DATA_WIDTH-1:1]};
  end

  assign take = o_VALID & i_READY;

  // Frame FSM, bit counter, holding register and status pulses.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      sr          <= '0;
      o_DATA      <= '0;
      o_VALID     <= 1'b0;
      o_BUSY      <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      o_OVERRUN   <= 1'b0;
    end else begin
      o_FRAME_ERR <= 1'b0;
      o_OVERRUN   <= 1'b0;
      if (take)
        o_VALID <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!cs_s2) begin
            state  <= RX_SHIFT;
            o_BUSY <= 1'b1;
          end
        end
        RX_SHIFT: begin
          if (cs_s2) begin
            // CS wins over a coincident SCLK edge.
            state       <= RX_IDLE;
            o_BUSY      <= 1'b0;
            cnt         <= '0;
            sr          <= '0;
            o_FRAME_ERR <= (cnt != '0);
          end else if (sclk_edge) begin
            sr <= sr_next;
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (!o_VALID || i_READY) begin
                o_DATA  <= sr_next;
                o_VALID <= 1'b1;
              end else begin
                o_OVERRUN <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/spi_shift_in_reg.md
Name: spi_shift_in_reg

Overview:
SPI slave receive deserializer for the MOSI direction. It samples raw pad-level SCLK/CS_N/MOSI in the i_CLK domain and assembles DATA_WIDTH-bit words, SPI mode 0 (sample on SCLK rising edge). Completed words go to a holding register with a valid/ready handshake toward the pedal control/register logic. It is the receive counterpart of the MISO shift-out path and shares the same CS framing.

Parameters:
DATA_WIDTH, 32, bits per received word (2..255)
MSB_FIRST, 1, 1 = first received bit lands in o_DATA[DATA_WIDTH-1]; 0 = first bit lands in o_DATA[0]

Ports:
i_CLK  input  1  system clock, sole clock of the block
i_RST_N  input  1  reset, synchronous, active-low
i_SCLK  input  1  raw SPI clock from pad, asynchronous to i_CLK
i_CS_N  input  1  raw chip select from pad, active-low, asynchronous
i_MOSI  input  1  raw serial data from pad, asynchronous
i_READY  input  1  consumer accepts o_DATA when o_VALID && i_READY
o_DATA  output  DATA_WIDTH  last completed word, stable while o_VALID=1
o_VALID  output  1  holding register contains an unaccepted word
o_BUSY  output  1  synchronized CS_N low (frame active)
o_FRAME_ERR  output  1  one-cycle pulse: CS_N deasserted mid-word
o_OVERRUN  output  1  one-cycle pulse: word completed while holding register full

Behaviour:
- Reset: reset is synchronous, active-low; all state changes on posedge i_CLK. With i_RST_N=0 at a posedge: o_DATA=0, o_VALID=0, o_BUSY=0, o_FRAME_ERR=0, o_OVERRUN=0. Shift register and bit counter clear. Sync flops reset to the idle level: SCLK=0, CS_N=1, MOSI=0. Reset mid-word discards the partial word and any held word.
- Synchronization: i_SCLK, i_CS_N and i_MOSI each pass through 2 flops. A third SCLK flop gives rising-edge detect: sclk_rise = s2 & ~s3. MOSI is sampled from its s2 flop on the sclk_rise cycle, so it has the same delay as SCLK. Timing requirement: SCLK high and low phases each >= 2 i_CLK periods. MOSI must be stable for >= 2 i_CLK periods around each SCLK rising edge.
- FSM states:
  - IDLE: cs_s2=1; counter held at 0; o_BUSY=0. Goes to SHIFT when cs_s2=0.
  - SHIFT: o_BUSY=1.
    - Each sclk_rise shifts in mos_s2 (left shift if MSB_FIRST, else right shift) and increments the counter.
    - When sclk_rise occurs with counter == DATA_WIDTH-1, the full word (including the current bit) is committed and the counter wraps to 0. Back-to-back words in one CS frame are supported.
    - Goes to IDLE when cs_s2=1.
- Latency: a raw SCLK rising edge before i_CLK edge k is detected in cycle k+1→k+2. The last bit's word is in o_DATA with o_VALID=1 after edge k+2, i.e. 3 i_CLK cycles.
- Commit rules:
  - If o_VALID=0, or o_VALID && i_READY in the commit cycle: load o_DATA, o_VALID=1.
  - If o_VALID=1 && !i_READY: the new word is dropped, o_DATA is kept, and o_OVERRUN pulses for 1 cycle.
- Handshake: o_VALID clears the cycle after o_VALID && i_READY, unless a commit happens in that same cycle, in which case it stays 1 with the new data. o_DATA never changes while o_VALID=1 && !i_READY.
- CS deassert: cs_s2 rising while in SHIFT with counter != 0 causes an o_FRAME_ERR 1-cycle pulse, discards the partial word and clears the counter; o_VALID/o_DATA are unaffected. If counter == 0 (clean word boundary), there is no error. An SCLK edge detected in the same cycle as cs_s2 rising is ignored.
- SCLK edges while in IDLE are ignored. The counter restarts at 0 on every new frame.
- Counter width: $clog2(DATA_WIDTH)+1 bits, no overflow possible.

Decomposition:
- Shared spi package: the mode-0 edge-select constant and sync-stage count (SPI_SYNC_STAGES=2), also used by the shift-out side.
- One natural sub-module: spi_in_sync, a 3-flop synchronizer with rising-edge output. It is instantiated for SCLK, and its s2 taps are reused for CS_N/MOSI.

Test Plan:
- Reset: hold i_RST_N=0 for 3 cycles while toggling pads → all outputs 0, o_BUSY=0. Release → no o_VALID.
- Single word, DATA_WIDTH=32, MSB_FIRST=1, send 0xA5C3_0F81 with SCLK = i_CLK/8 and i_READY=1 → o_VALID pulses 1 cycle with o_DATA=0xA5C30F81 exactly 3 cycles after the 32nd SCLK rise. MSB_FIRST=0 with the same bit stream → o_DATA=0x81F0C3A5 (bit-reversed).
- Back-to-back: 2 words 0x00000001, 0xFFFFFFFE in one CS frame, i_READY=1 → two commits in order, no o_FRAME_ERR.
- Overrun: i_READY=0, send 0x11111111 then 0x22222222 → o_DATA stays 0x11111111 and o_OVERRUN pulses once. Raise i_READY → 0x11111111 accepted, then o_VALID=0.
- Frame error: CS_N high after 13 bits → o_FRAME_ERR 1-cycle pulse, no commit. The next full frame 0xDEADBEEF is received correctly.
- Reset mid-word: assert i_RST_N=0 after 20 bits, release, send 0x12345678 → o_DATA=0x12345678 with no corruption from the prior bits.
